jk_mod_counter: RTL and testbench

Synchronous modulo-MOD up/down counter built as a bank of JK flip-flop cells, with the excitation logic that drives them. It is the stage directly upstream of the JK flip-flop: it computes per-bit J/K excitation from the current state and control inputs, feeds them to its internal cells, and exports J/K so the flip-flop stage can be probed or driven externally. It is the first multi-bit sequential block in the flip-flop library.

---
 rtl/jk_pkg.sv | 15 +
 rtl/jk_cell.sv | 34 +++
 rtl/jk_mod_counter.sv | 84 ++++++++
 tb/tb_jk_mod_counter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop library: cell excitation encodings
// and the elaboration-time legality check on a counter modulus.
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   // True when a WIDTH-bit state can hold every count 0..mod-1.
   function automatic bit mod_is_legal(int width, int mod);
      return (mod >= 2) && (mod <= (1 << width));
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high clear and a
// complementary output.
module jk_cell
   import jk_pkg::*;
(
   input  logic CLK,
   input  logic CLR,
   input  logic J,
   input  logic K,
   output logic Q,
   output logic P
);

   logic r_q;

   // NOTE: sequential state uses non-blocking assignments so every cell samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_q <= 1'b0;
      end else begin
         case ({J, K})
            JK_HOLD: r_q <= r_q;
            JK_RST:  r_q <= 1'b0;
            JK_SET:  r_q <= 1'b1;
            JK_TOG:  r_q <= ~r_q;
            default: r_q <= r_q;
         endcase
      end
   end

   assign Q = r_q;
   assign P = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from JK cells; the top computes the next
// state, derives minimal J/K excitation from it, and decodes TC and LERR.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             EN,
   input  logic             UP,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] P,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             TC,
   output logic             LERR
);

   if (!mod_is_legal(WIDTH, MOD)) begin : g_bad_mod
      $error("jk_mod_counter: MOD out of range for WIDTH");
   end

   // One extra bit so MOD == 2**WIDTH is representable.
   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);
   localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_next;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_load_bad;
   logic             r_lerr;

   assign w_at_max   = ({1'b0, w_q} == MAX_W);
   assign w_at_zero  = (w_q == '0);
   assign w_load_bad = ({1'b0, D} >= MOD_W);

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      w_next = w_q;
      J      = '0;
      K      = '0;
      if (CLR) begin
         w_next = '0;
      end else begin
         if (LD) begin
            w_next = w_load_bad ? '0 : D;
         end else if (EN) begin
            if (UP) w_next = w_at_max  ? '0 : w_q + 1'b1;
            else    w_next = w_at_zero ? MAX_W[WIDTH-1:0] : w_q - 1'b1;
         end
         J = ~w_q & w_next;
         K = w_q & ~w_next;
      end
   end

   assign TC = EN & ~LD & ~CLR & ((UP & w_at_max) | (~UP & w_at_zero));

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .CLK (CLK),
         .CLR (CLR),
         .J   (J[i]),
         .K   (K[i]),
         .Q   (w_q[i]),
         .P   (w_p[i])
      );
   end

   always_ff @(posedge CLK) begin
      if (CLR) r_lerr <= 1'b0;
      else     r_lerr <= LD & w_load_bad;
   end

   assign Q    = w_q;
   assign P    = w_p;
   assign LERR = r_lerr;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: MOD=10 and MOD=16 builds share stimulus and are
// checked against an integer modular-arithmetic model.
module tb_jk_mod_counter;

   logic       CLK = 1'b0;
   logic       CLR, EN, UP, LD;
   logic [3:0] D;

   logic [3:0] q10, p10, j10, k10;
   logic       tc10, lerr10;
   logic [3:0] q16, p16, j16, k16;
   logic       tc16, lerr16;

   int n_cmp = 0;
   int n_err = 0;
   int m_q10, m_q16;
   bit m_lerr10, m_lerr16;

   always #5 CLK = ~CLK;

   jk_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LD(LD), .D(D),
      .Q(q10), .P(p10), .J(j10), .K(k10), .TC(tc10), .LERR(lerr10)
   );

   jk_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LD(LD), .D(D),
      .Q(q16), .P(p16), .J(j16), .K(k16), .TC(tc16), .LERR(lerr16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Next count from the current inputs, as plain modular arithmetic.
   function automatic int model_next(int q, int mod);
      if (CLR)      return 0;
      else if (LD)  return (int'(D) < mod) ? int'(D) : 0;
      else if (EN)  return UP ? (q + 1) % mod : (q + mod - 1) % mod;
      else          return q;
   endfunction

   function automatic logic [31:0] exp_tc(int q, int mod);
      return {31'd0, EN && !LD && !CLR && ((UP && q == mod - 1) || (!UP && q == 0))};
   endfunction

   task automatic check_comb();
      int n10, n16;
      n10 = model_next(m_q10, 10);
      n16 = model_next(m_q16, 16);
      check("j10",  {28'd0, j10}, CLR ? 32'd0 : 32'((~m_q10 & n10) & 15));
      check("k10",  {28'd0, k10}, CLR ? 32'd0 : 32'((m_q10 & ~n10) & 15));
      check("tc10", {31'd0, tc10}, exp_tc(m_q10, 10));
      check("j16",  {28'd0, j16}, CLR ? 32'd0 : 32'((~m_q16 & n16) & 15));
      check("k16",  {28'd0, k16}, CLR ? 32'd0 : 32'((m_q16 & ~n16) & 15));
      check("tc16", {31'd0, tc16}, exp_tc(m_q16, 16));
   endtask

   task automatic check_regs();
      check("q10",    {28'd0, q10},    32'(m_q10));
      check("p10",    {28'd0, p10},    32'(15 - m_q10));
      check("lerr10", {31'd0, lerr10}, {31'd0, m_lerr10});
      check("q16",    {28'd0, q16},    32'(m_q16));
      check("p16",    {28'd0, p16},    32'(15 - m_q16));
      check("lerr16", {31'd0, lerr16}, {31'd0, m_lerr16});
   endtask

   // One clock: drive inputs, check combinational outputs, advance the model, check state.
   task automatic cyc(input bit clr, input bit ld, input bit en, input bit up, input int d);
      int n10, n16;
      CLR = clr; LD = ld; EN = en; UP = up; D = 4'(d);
      #1;
      check_comb();
      n10 = model_next(m_q10, 10);
      n16 = model_next(m_q16, 16);
      @(posedge CLK);
      m_lerr10 = !clr && ld && (d >= 10);
      m_lerr16 = !clr && ld && (d >= 16);
      m_q10 = n10;
      m_q16 = n16;
      #1;
      check_regs();
   endtask

   initial begin
      CLR = 1'b0; LD = 1'b0; EN = 1'b0; UP = 1'b1; D = '0;
      m_q10 = 0; m_q16 = 0; m_lerr10 = 0; m_lerr16 = 0;
      @(posedge CLK);
      #1;

      // Reset overrides load and enable.
      cyc(1, 1, 1, 1, 5);
      cyc(1, 1, 1, 1, 5);

      // Count up through the wrap and one step beyond.
      for (int i = 0; i < 11; i++) cyc(0, 0, 1, 1, 0);
      // Count down from 1 through 0 to MOD-1 and below.
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);

      // Loads: in range, out of range (MOD=10 only), then idle to see LERR drop.
      cyc(0, 1, 0, 0, 7);
      cyc(0, 1, 0, 0, 12);
      cyc(0, 0, 0, 0, 0);

      // Hold at 3, load beats enable, clear beats load.
      cyc(0, 1, 0, 0, 3);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 1, 1, 2);
      cyc(0, 1, 0, 0, 6);
      cyc(1, 1, 1, 1, 9);

      // Top of the full-range counter: load 15, then wrap upward.
      cyc(0, 1, 0, 0, 15);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 1, 0);

      // Direction flips with no dead cycle.
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0);

      // Randomized mix of all controls.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 99) < 4),
             ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 70),
             1'($urandom),
             int'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
